// File: rtl/mult_seq_pkg.sv
// Shared types and constants for the sequential shift-add multiplier that borrows the execute-stage ALU.
package mult_seq_pkg;

    localparam int MUL_WIDTH = 16;
    localparam logic [2:0] MUL_ALU_OP_ADD = 3'b100;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mulStateT;

endpackage

// File: rtl/mult_seq_dp.sv
// Multiplier datapath: accumulator, shifting multiplicand/multiplier, iteration counter and result register.
module mult_seq_dp
    import mult_seq_pkg::*;
#(
    parameter int WIDTH = MUL_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             step,
    input  logic             capture,
    input  logic [WIDTH-1:0] opA,
    input  logic [WIDTH-1:0] opB,
    input  logic [WIDTH-1:0] aluOut,
    output logic [WIDTH-1:0] acc,
    output logic [WIDTH-1:0] mcand,
    output logic             mplierLsb,
    output logic             last,
    output logic [WIDTH-1:0] result
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic [WIDTH-1:0] mplier;
    logic [CNT_W-1:0] cnt;

    assign mplierLsb = mplier[0];
    assign last      = (cnt == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            cnt    <= '0;
            result <= '0;
        end else begin
            if (load) begin
                acc    <= '0;
                mcand  <= opA;
                mplier <= opB;
                cnt    <= '0;
            end else if (step) begin
                acc    <= aluOut;
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
                cnt    <= cnt + CNT_W'(1);
            end
            // Final ALU sum is taken straight from the ALU so result is valid in the DONE cycle.
            if (capture) begin
                result <= aluOut;
            end
        end
    end

endmodule

// File: rtl/mult_seq_ctrl.sv
// Sequencer that owns the shared execute-stage ALU for WIDTH cycles to form the low half of a product.
module mult_seq_ctrl
    import mult_seq_pkg::*;
#(
    parameter int         WIDTH      = MUL_WIDTH,
    parameter logic [2:0] ALU_OP_ADD = MUL_ALU_OP_ADD
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             flush,
    input  logic [WIDTH-1:0] alu_out,
    output logic             alu_sel,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_op,
    output logic             inv_a,
    output logic             inv_b,
    output logic             cin,
    output logic             busy,
    output logic             stall,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    mulStateT         state, stateNext;
    logic             load, step, capture;
    logic [WIDTH-1:0] acc, mcand;
    logic             mplierLsb, last;

    mult_seq_dp #(.WIDTH(WIDTH)) uDp (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .step      (step),
        .capture   (capture),
        .opA       (op_a),
        .opB       (op_b),
        .aluOut    (alu_out),
        .acc       (acc),
        .mcand     (mcand),
        .mplierLsb (mplierLsb),
        .last      (last),
        .result    (result)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        load      = 1'b0;
        step      = 1'b0;
        capture   = 1'b0;
        case (state)
            IDLE: begin
                if (start && !flush) begin
                    load      = 1'b1;
                    stateNext = RUN;
                end
            end
            RUN: begin
                step = 1'b1;
                if (last) begin
                    capture   = 1'b1;
                    stateNext = DONE;
                end
            end
            DONE:    stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
        // Squash wins over everything, including the final capture.
        if (flush) begin
            stateNext = IDLE;
            load      = 1'b0;
            step      = 1'b0;
            capture   = 1'b0;
        end
    end

    // Operands are forced to zero whenever the execute mux is not selecting this block.
    assign alu_sel = (state == RUN);
    assign alu_a   = alu_sel ? acc : '0;
    assign alu_b   = (alu_sel && mplierLsb) ? mcand : '0;
    assign alu_op  = ALU_OP_ADD;
    assign inv_a   = 1'b0;
    assign inv_b   = 1'b0;
    assign cin     = 1'b0;

    assign busy  = (state != IDLE);
    assign stall = (state == RUN) || ((state == IDLE) && start && !flush);
    assign done  = (state == DONE) && !flush;

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Directed bench for mult_seq_ctrl with a behavioural ALU and a scoreboard on the done pulse.
module tb_mult_seq_ctrl;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] opA, opB;
    logic         flush;
    logic [W-1:0] aluOut;
    logic         aluSel;
    logic [W-1:0] aluA, aluB;
    logic [2:0]   aluOp;
    logic         invA, invB, cin;
    logic         busy, stall, done;
    logic [W-1:0] result;

    mult_seq_ctrl #(.WIDTH(W), .ALU_OP_ADD(3'b100)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .op_a    (opA),
        .op_b    (opB),
        .flush   (flush),
        .alu_out (aluOut),
        .alu_sel (aluSel),
        .alu_a   (aluA),
        .alu_b   (aluB),
        .alu_op  (aluOp),
        .inv_a   (invA),
        .inv_b   (invB),
        .cin     (cin),
        .busy    (busy),
        .stall   (stall),
        .done    (done),
        .result  (result)
    );

    // Shared ALU stand-in: ADD only, carry dropped.
    assign aluOut = aluA + aluB;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [W-1:0] res;
        int           cyc;
    } expT;

    expT expQ[$];
    int  vectors = 0;
    int  miscompares = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst === 1'b0 && done === 1'b1) begin
            if (expQ.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                expT e;
                e = expQ.pop_front();
                check("result", {16'd0, result}, {16'd0, e.res});
                check("latency", cyc, e.cyc);
            end
        end
    end

    int stallCnt, selCnt, bNonZero, doneCnt;

    // Issues one start pulse and watches the following 20 cycles.
    task automatic runMul(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] expRes);
        expT e;
        @(posedge clk); #1;
        start = 1'b1; opA = a; opB = b;
        e.res = expRes;
        e.cyc = cyc + 17;
        expQ.push_back(e);
        stallCnt = 0; selCnt = 0; bNonZero = 0; doneCnt = 0;
        @(negedge clk);
        stallCnt += int'(stall);
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 19; i++) begin
            @(negedge clk);
            stallCnt += int'(stall);
            selCnt   += int'(aluSel);
            doneCnt  += int'(done);
            if (aluSel && aluB != '0) bNonZero++;
        end
    endtask

    task automatic waitDrain();
        int n = 0;
        while (expQ.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("scoreboard_drained", expQ.size(), 0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; flush = 1'b0; opA = '0; opB = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_stall", stall, 0);
        check("rst_alu_sel", aluSel, 0);
        check("rst_done", done, 0);
        check("rst_result", result, 0);
        check("rst_alu_ab", {aluA, aluB}, 0);
        check("alu_op_add", {aluOp, invA, invB, cin}, 32'b100_000);
        @(posedge clk); #1;
        rst = 1'b0;

        runMul(16'd3, 16'd5, 16'h000F);
        check("stall_cycles", stallCnt, 17);
        check("alu_sel_cycles", selCnt, 16);
        check("done_pulses", doneCnt, 1);

        runMul(16'h0100, 16'h0100, 16'h0000);
        runMul(16'hFFFF, 16'hFFFF, 16'h0001);

        runMul(16'h1234, 16'h0000, 16'h0000);
        check("zero_mplier_alu_b", bNonZero, 0);
        check("zero_mplier_sel", selCnt, 16);
        waitDrain();

        // Start re-pulsed in RUN and in DONE with other operands must be ignored.
        begin
            expT e;
            @(posedge clk); #1;
            start = 1'b1; opA = 16'd7; opB = 16'd9;
            e.res = 16'h003F; e.cyc = cyc + 17;
            expQ.push_back(e);
            for (int i = 1; i <= 20; i++) begin
                @(posedge clk); #1;
                start = (i == 5 || i == 17);
                opA = (i >= 5) ? 16'd2 : 16'd7;
                opB = (i >= 5) ? ((i >= 17) ? 16'd3 : 16'd2) : 16'd9;
                if (i == 17) begin
                    @(negedge clk);
                    check("stall_in_done", stall, 0);
                    check("done_with_start", done, 1);
                end
            end
            start = 1'b0;
            @(negedge clk);
            check("ignored_start_idle", busy, 0);
            check("ignored_start_result", result, 16'h003F);
        end
        waitDrain();

        // Flush at RUN cycle 8: no done, prior result kept.
        @(posedge clk); #1;
        start = 1'b1; opA = 16'd3; opB = 16'd5;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (7) @(posedge clk);
        #1 flush = 1'b1;
        @(negedge clk);
        check("flush_cycle_stall", stall, 1);
        check("flush_cycle_done", done, 0);
        @(posedge clk); #1;
        flush = 1'b0;
        @(negedge clk);
        check("flush_busy", busy, 0);
        check("flush_stall", stall, 0);
        check("flush_alu_sel", aluSel, 0);
        check("flush_result", result, 16'h003F);
        repeat (20) @(negedge clk);
        check("flush_result_later", result, 16'h003F);

        // Flush together with start in IDLE drops the start.
        @(posedge clk); #1;
        start = 1'b1; flush = 1'b1; opA = 16'd4; opB = 16'd4;
        @(negedge clk);
        check("flush_start_stall", stall, 0);
        @(posedge clk); #1;
        start = 1'b0; flush = 1'b0;
        @(negedge clk);
        check("flush_start_busy", busy, 0);

        // Asynchronous reset in the middle of RUN.
        @(posedge clk); #1;
        start = 1'b1; opA = 16'd3; opB = 16'd5;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        check("pre_rst_alu_sel", aluSel, 1);
        rst = 1'b1;
        #1;
        check("async_rst_alu_sel", aluSel, 0);
        check("async_rst_stall", stall, 0);
        check("async_rst_busy", busy, 0);
        check("async_rst_result", result, 0);
        @(negedge clk);
        rst = 1'b0;

        runMul(16'd2, 16'd3, 16'h0006);
        check("post_rst_alu_sel_cycles", selCnt, 16);
        waitDrain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
